// File: rtl/alu_div_ctrl_pkg.sv
// Shared definitions for the divide sequencer: ALUControl codes, flag
// positions and the controller state encoding.
package alu_div_ctrl_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_EOR = 4'b0110;
    localparam logic [3:0] ALU_RSB = 4'b1000;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_NEG_N = 3'd1,
        ST_NEG_D = 3'd2,
        ST_ITER  = 3'd3,
        ST_FIX_Q = 3'd4,
        ST_FIX_R = 3'd5,
        ST_DONE  = 3'd6
    } div_state_e;

endpackage

// File: rtl/alu_div_ctrl_alu_owner_mux.sv
// Selects who drives the shared ALU: the pipeline when the divider is idle,
// the divide controller while it owns the ALU.
module alu_owner_mux #(
    parameter int unsigned XLEN = 32
) (
    input  logic            busy,
    input  logic [XLEN-1:0] ex_a,
    input  logic [XLEN-1:0] ex_b,
    input  logic [3:0]      ex_ctrl,
    input  logic [XLEN-1:0] ctl_a,
    input  logic [XLEN-1:0] ctl_b,
    input  logic [3:0]      ctl_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl
);

    always_comb begin
        alu_a    = ex_a;
        alu_b    = ex_b;
        alu_ctrl = ex_ctrl;
        if (busy) begin
            alu_a    = ctl_a;
            alu_b    = ctl_b;
            alu_ctrl = ctl_ctrl;
        end
    end

endmodule

// File: rtl/alu_div_ctrl.sv
// Multi-cycle restoring divider that borrows the execute-stage ALU for one
// operation per cycle and stalls the pipeline until the result is ready.
module alu_div_ctrl
    import alu_div_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            signed_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic [XLEN-1:0] ex_a,
    input  logic [XLEN-1:0] ex_b,
    input  logic [3:0]      ex_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    input  logic [3:0]      alu_flags,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_by_zero
);

    div_state_e      state_q, state_d;
    logic [XLEN-1:0] n_q, n_d;
    logic [XLEN-1:0] d_q, d_d;
    logic [XLEN-1:0] r_q, r_d;
    logic [4:0]      cnt_q, cnt_d;
    logic            sign_n_q, sign_n_d;
    logic            sign_d_q, sign_d_d;
    logic [XLEN-1:0] quotient_q, quotient_d;
    logic [XLEN-1:0] remainder_q, remainder_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    logic [XLEN-1:0] ctl_a, ctl_b;
    logic [3:0]      ctl_ctrl;
    logic [XLEN-1:0] rs;
    logic            r_msb;
    logic            qbit;
    logic            unused_flags;

    assign unused_flags = ^{alu_flags[FLAG_N], alu_flags[FLAG_Z], alu_flags[FLAG_V]};

    assign busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign stall = ((state_q == ST_IDLE) && start) || busy;

    // 33-bit partial remainder {r_msb, rs}; r_msb set means it already exceeds D
    assign rs    = {r_q[XLEN-2:0], n_q[XLEN-1]};
    assign r_msb = r_q[XLEN-1];
    assign qbit  = r_msb | alu_flags[FLAG_C];

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        d_d         = d_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        sign_n_d    = sign_n_q;
        sign_d_d    = sign_d_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        ctl_a       = '0;
        ctl_b       = '0;
        ctl_ctrl    = ALU_ADD;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_d      = dividend;
                    d_d      = divisor;
                    r_d      = '0;
                    cnt_d    = 5'd31;
                    sign_n_d = signed_op & dividend[XLEN-1];
                    sign_d_d = signed_op & divisor[XLEN-1];
                    dbz_d    = 1'b0;
                    if (divisor == '0) begin
                        state_d     = ST_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else if (signed_op & dividend[XLEN-1]) begin
                        state_d = ST_NEG_N;
                    end else if (signed_op & divisor[XLEN-1]) begin
                        state_d = ST_NEG_D;
                    end else begin
                        state_d = ST_ITER;
                    end
                end
            end
            ST_NEG_N: begin
                ctl_a    = n_q;
                ctl_ctrl = ALU_RSB;
                n_d      = alu_result;
                state_d  = sign_d_q ? ST_NEG_D : ST_ITER;
            end
            ST_NEG_D: begin
                ctl_a    = d_q;
                ctl_ctrl = ALU_RSB;
                d_d      = alu_result;
                state_d  = ST_ITER;
            end
            ST_ITER: begin
                ctl_a    = rs;
                ctl_b    = d_q;
                ctl_ctrl = ALU_SUB;
                r_d      = qbit ? alu_result : rs;
                n_d      = {n_q[XLEN-2:0], qbit};
                cnt_d    = cnt_q - 5'd1;
                if (cnt_q == '0) begin
                    if (sign_n_q ^ sign_d_q) begin
                        state_d = ST_FIX_Q;
                    end else if (sign_n_q) begin
                        state_d = ST_FIX_R;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FIX_Q: begin
                ctl_a    = n_q;
                ctl_ctrl = ALU_RSB;
                n_d      = alu_result;
                state_d  = sign_n_q ? ST_FIX_R : ST_DONE;
            end
            ST_FIX_R: begin
                ctl_a    = r_q;
                ctl_ctrl = ALU_RSB;
                r_d      = alu_result;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Results are captured on entry to DONE so they are valid alongside done.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            done_d = 1'b1;
            if (!dbz_d) begin
                quotient_d  = n_d;
                remainder_d = r_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            sign_n_q    <= 1'b0;
            sign_d_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            d_q         <= d_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            sign_n_q    <= sign_n_d;
            sign_d_q    <= sign_d_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;

    alu_owner_mux #(
        .XLEN(XLEN)
    ) u_alu_owner_mux (
        .busy    (busy),
        .ex_a    (ex_a),
        .ex_b    (ex_b),
        .ex_ctrl (ex_ctrl),
        .ctl_a   (ctl_a),
        .ctl_b   (ctl_b),
        .ctl_ctrl(ctl_ctrl),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_ctrl(alu_ctrl)
    );

endmodule

// File: tb/tb_alu_div_ctrl.sv
// Self-checking bench for alu_div_ctrl: a behavioural ALU closes the loop and
// results are compared against plain-arithmetic division.
module tb_alu_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend, divisor;
    logic [31:0] ex_a, ex_b;
    logic [3:0]  ex_ctrl;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        stall, busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_div_ctrl #(.XLEN(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_ctrl    (ex_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // Behavioural ALU; C is the carry out (no borrow) for SUB/RSB.
    logic [32:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        case (alu_ctrl)
            4'b0000: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0001: alu_wide = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
            4'b1000: alu_wide = {1'b0, alu_b} + {1'b0, ~alu_a} + 33'd1;
            4'b0010: alu_wide = {1'b0, alu_a & alu_b};
            4'b0011: alu_wide = {1'b0, alu_a | alu_b};
            4'b0110: alu_wide = {1'b0, alu_a ^ alu_b};
            default: alu_wide = '0;
        endcase
        alu_result = alu_wide[31:0];
        alu_flags  = {alu_wide[31], alu_wide[31:0] == 32'd0, alu_wide[32], 1'b0};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz, output int lat);
        int sn, sd;
        sn = (sg && a[31]) ? 1 : 0;
        sd = (sg && b[31]) ? 1 : 0;
        if (b == 32'd0) begin
            q = '1; r = a; dz = 1'b1; lat = 1;
            return;
        end
        dz = 1'b0;
        if (!sg) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        // 32 iterations plus one cycle per negation: operand fix-ups, quotient
        // fix when signs differ, remainder fix when the dividend was negative.
        lat = 33 + sn + sd + (sn ^ sd) + sn;
    endfunction

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input bit noise, input string tag);
        logic [31:0] eq, er;
        logic        edz;
        int          elat, lat;
        bit          held;
        ref_div(a, b, sg, eq, er, edz, elat);
        @(negedge clk);
        start = 1'b1; signed_op = sg; dividend = a; divisor = b;
        #1 check({tag, "_stall_start"}, {63'd0, stall}, 64'd1);
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom; signed_op = $urandom_range(0, 1);
        lat  = 1;
        held = 1'b1;
        while (!done && lat < 60) begin
            if (!stall || !busy) held = 1'b0;
            if (noise) begin
                start   = $urandom_range(0, 1);
                ex_a    = $urandom;
                ex_b    = $urandom;
                ex_ctrl = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        check({tag, "_stall_held"}, {63'd0, held}, 64'd1);
        check({tag, "_quot"}, {32'd0, quotient}, {32'd0, eq});
        check({tag, "_rem"}, {32'd0, remainder}, {32'd0, er});
        check({tag, "_flags_done"}, {60'd0, done, div_by_zero, stall, busy}, {60'd0, 1'b1, edz, 2'b00});
        @(negedge clk);
        start = 1'b0;
        #1 check({tag, "_after"}, {32'd0, quotient ^ remainder, done, div_by_zero, busy},
                 {32'd0, eq ^ er, 1'b0, edz, 1'b0});
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          no_done;
        reset = 1'b0; start = 1'b0; signed_op = 1'b0;
        dividend = '0; divisor = '0; ex_a = '0; ex_b = '0; ex_ctrl = '0;
        repeat (2) @(negedge clk);
        check("reset_flags", {60'd0, stall, busy, done, div_by_zero}, 64'd0);
        check("reset_results", {quotient, remainder}, 64'd0);
        reset = 1'b1;

        @(negedge clk);
        ex_a = 32'd5; ex_b = 32'd3; ex_ctrl = 4'b0001;
        #1 check("passthrough", {28'd0, alu_a, alu_ctrl}, {28'd0, 32'd5, 4'b0001});
        check("passthrough_b", {32'd0, alu_b}, 64'd3);

        do_div(32'd100, 32'd7, 1'b0, 1'b0, "u100_7");
        do_div(-32'sd100, 32'd7, 1'b1, 1'b0, "sm100_7");
        do_div(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, "uffff_8000");
        do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "uffff_ffff");
        do_div(32'd1234, 32'd0, 1'b0, 1'b0, "div0");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "smin_m1");
        do_div(32'd7, 32'hFFFF_FFF9, 1'b1, 1'b0, "s7_m7");

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(1, 255));
                2: rb = $urandom_range(0, 3) == 0 ? 32'd0 : ~32'($urandom_range(0, 40));
                default: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            endcase
            do_div(ra, rb, 1'($urandom_range(0, 1)), 1'b1, $sformatf("rnd%0d", i));
        end

        @(negedge clk);
        ex_a = 32'd11; ex_b = 32'd22; ex_ctrl = 4'b0011;
        start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1 check("abort_flags", {60'd0, stall, busy, done, div_by_zero}, 64'd0);
        check("abort_results", {quotient, remainder}, 64'd0);
        check("abort_passthrough", {28'd0, alu_a, alu_ctrl}, {28'd0, 32'd11, 4'b0011});
        no_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) no_done = 1'b0;
        end
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) no_done = 1'b0;
        end
        check("abort_no_done", {63'd0, no_done}, 64'd1);

        do_div(32'd9, 32'd3, 1'b0, 1'b0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
